// File: rtl/data_ram_pkg.sv
// Shared constants and memory-access encodings for the data RAM.
// Also used by the memory stage when issuing stores.
package data_ram_pkg;

  localparam int XLEN_WIDTH = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    MEM_NONE = 2'b00,
    MEM_BYTE = 2'b01,
    MEM_HALF = 2'b10,
    MEM_WORD = 2'b11
  } mem_mode_e;

endpackage

// File: rtl/ram_lane_gen.sv
// Store lane steering: mode + addr[1:0] + data -> byte enables, lane data.
// Ports: i_mode, i_lane, i_data in; o_be, o_data, o_misalign out.
module ram_lane_gen
  import data_ram_pkg::*;
(
  input  logic [1:0]            i_mode,
  input  logic [1:0]            i_lane,
  input  logic [XLEN_WIDTH-1:0] i_data,
  output logic [3:0]            o_be,
  output logic [XLEN_WIDTH-1:0] o_data,
  output logic                  o_misalign
);

  // Data is replicated across lanes so the byte enables alone
  // pick which copy lands in storage.
  always_comb begin
    o_be       = 4'b0000;
    o_data     = i_data;
    o_misalign = FALSE;
    unique case (1'b1)
      (i_mode == MEM_BYTE): begin
        o_be   = 4'b0001 << i_lane;
        o_data = {4{i_data[7:0]}};
      end
      (i_mode == MEM_HALF): begin
        o_be       = i_lane[1] ? 4'b1100 : 4'b0011;
        o_data     = {2{i_data[15:0]}};
        o_misalign = i_lane[0];
      end
      (i_mode == MEM_WORD): begin
        o_be       = 4'b1111;
        o_misalign = |i_lane;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_ram.sv
// Word-organised data RAM: byte/half/word stores, 1-cycle word reads.
// Ports: clk, rst_n, read req/resp, write req, fault pulse + address.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int                    DEPTH     = 4096,
  parameter logic [XLEN_WIDTH-1:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ram_read_en,
  input  logic [XLEN_WIDTH-1:0] ram_read_addr,
  output logic [XLEN_WIDTH-1:0] ram_read_data,
  output logic                  ram_read_valid,
  input  logic [1:0]            ram_write_mode,
  input  logic [XLEN_WIDTH-1:0] ram_write_addr,
  input  logic [XLEN_WIDTH-1:0] ram_write_data,
  output logic                  ram_fault,
  output logic [XLEN_WIDTH-1:0] ram_fault_addr
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN_WIDTH-1:0] r_mem [DEPTH];

  logic [XLEN_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;
  logic                  r_fault;
  logic [XLEN_WIDTH-1:0] r_faddr;

  logic [XLEN_WIDTH-1:0] w_roff;
  logic [XLEN_WIDTH-1:0] w_woff;
  logic                  w_rin;
  logic                  w_win;
  logic [AW-1:0]         w_ridx;
  logic [AW-1:0]         w_widx;
  logic [3:0]            w_be;
  logic [XLEN_WIDTH-1:0] w_wdata;
  logic                  w_mis;
  logic                  w_wreq;
  logic                  w_wfault;
  logic                  w_rfault;
  logic                  w_we;
  logic [XLEN_WIDTH-1:0] w_rword;
  logic                  w_unused_bits;

  assign w_roff = ram_read_addr - ADDR_BASE;
  assign w_woff = ram_write_addr - ADDR_BASE;

  // DEPTH is a power of two, so in-range means the offset
  // has no bits above the word index.
  assign w_rin = (ram_read_addr >= ADDR_BASE)
              && (w_roff[XLEN_WIDTH-1:AW+2] == '0);
  assign w_win = (ram_write_addr >= ADDR_BASE)
              && (w_woff[XLEN_WIDTH-1:AW+2] == '0);

  assign w_ridx = w_roff[AW+1:2];
  assign w_widx = w_woff[AW+1:2];

  assign w_unused_bits = ^{w_roff[1:0], w_woff[1:0]};

  ram_lane_gen u_lane (
    .i_mode     (ram_write_mode),
    .i_lane     (ram_write_addr[1:0]),
    .i_data     (ram_write_data),
    .o_be       (w_be),
    .o_data     (w_wdata),
    .o_misalign (w_mis)
  );

  assign w_wreq   = (ram_write_mode != MEM_NONE);
  assign w_wfault = w_wreq && (w_mis || !w_win);
  assign w_rfault = ram_read_en && !w_rin;
  assign w_we     = rst_n && w_wreq && !w_wfault;

  // Storage has no reset: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_widx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  // Write-first: fold a same-word store into the read word.
  always_comb begin
    w_rword = r_mem[w_ridx];
    if (w_we && (w_widx == w_ridx)) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          w_rword[8*i +: 8] = w_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= FALSE;
      r_fault  <= FALSE;
      r_faddr  <= '0;
    end else begin
      r_rvalid <= ram_read_en;
      if (ram_read_en) begin
        r_rdata <= w_rfault ? '0 : w_rword;
      end
      r_fault <= w_wfault | w_rfault;
      if (w_wfault) begin
        r_faddr <= ram_write_addr;
      end else if (w_rfault) begin
        r_faddr <= ram_read_addr;
      end
    end
  end

  assign ram_read_data  = r_rdata;
  assign ram_read_valid = r_rvalid;
  assign ram_fault      = r_fault;
  assign ram_fault_addr = r_faddr;

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: directed table, reset sequence,
// and random traffic against a byte-array reference model.
module tb_data_ram;
  import data_ram_pkg::*;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ram_read_en = 1'b0;
  logic [31:0] ram_read_addr = '0;
  logic [31:0] ram_read_data;
  logic        ram_read_valid;
  logic [1:0]  ram_write_mode = MEM_NONE;
  logic [31:0] ram_write_addr = '0;
  logic [31:0] ram_write_data = '0;
  logic        ram_fault;
  logic [31:0] ram_fault_addr;

  data_ram #(
    .DEPTH     (DEPTH),
    .ADDR_BASE (BASE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ram_read_en    (ram_read_en),
    .ram_read_addr  (ram_read_addr),
    .ram_read_data  (ram_read_data),
    .ram_read_valid (ram_read_valid),
    .ram_write_mode (ram_write_mode),
    .ram_write_addr (ram_write_addr),
    .ram_write_data (ram_write_data),
    .ram_fault      (ram_fault),
    .ram_fault_addr (ram_fault_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0]  m_mem [DEPTH*4];
  logic [31:0] m_data = '0;
  logic        m_valid = 1'b0;
  logic        m_fault = 1'b0;
  logic [31:0] m_faddr = '0;

  typedef struct {
    logic        re;
    logic [31:0] raddr;
    logic [1:0]  mode;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] e_data;
    logic        e_valid;
    logic        e_fault;
    logic [31:0] e_faddr;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 2) < DEPTH);
  endfunction

  // Reference: apply the store byte by byte, then read (write-first).
  task automatic model_step(input logic re, input logic [31:0] ra,
                            input logic [1:0] md, input logic [31:0] wa,
                            input logic [31:0] wd);
    int  sz;
    int  b;
    bit  wok;
    bit  wf;
    bit  rf;
    sz  = (md == 2'b01) ? 1 : (md == 2'b10) ? 2 : 4;
    wok = (md != 2'b00) && ((wa % sz) == 0) && in_range(wa);
    wf  = (md != 2'b00) && !wok;
    if (wok)
      for (int k = 0; k < sz; k++)
        m_mem[int'(wa - BASE) + k] = wd[8*k +: 8];
    rf = re && !in_range(ra);
    m_valid = re;
    if (re) begin
      if (rf) m_data = '0;
      else begin
        b = int'((ra - BASE) & 32'hFFFF_FFFC);
        m_data = {m_mem[b+3], m_mem[b+2], m_mem[b+1], m_mem[b]};
      end
    end
    m_fault = wf || rf;
    if (wf) m_faddr = wa;
    else if (rf) m_faddr = ra;
  endtask

  task automatic step(input logic re, input logic [31:0] ra,
                      input logic [1:0] md, input logic [31:0] wa,
                      input logic [31:0] wd);
    @(negedge clk);
    ram_read_en    = re;
    ram_read_addr  = ra;
    ram_write_mode = md;
    ram_write_addr = wa;
    ram_write_data = wd;
    model_step(re, ra, md, wa, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".data"},  ram_read_data,         m_data);
    chk({tag, ".valid"}, 32'(ram_read_valid),   32'(m_valid));
    chk({tag, ".fault"}, 32'(ram_fault),        32'(m_fault));
    chk({tag, ".faddr"}, ram_fault_addr,        m_faddr);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".data"},  ram_read_data,       32'h0);
    chk({tag, ".valid"}, 32'(ram_read_valid), 32'h0);
    chk({tag, ".fault"}, 32'(ram_fault),      32'h0);
    chk({tag, ".faddr"}, ram_fault_addr,      32'h0);
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 7))
      0:       return $urandom;
      1:       return 32'(DEPTH*4) + $urandom_range(0, 15);
      default: return $urandom_range(0, DEPTH*4 - 1);
    endcase
  endfunction

  initial begin
    logic        re;
    logic [31:0] ra;
    logic [31:0] wa;
    logic [1:0]  md;

    for (int i = 0; i < DEPTH*4; i++) m_mem[i] = 8'h00;

    tbl[0]  = '{0, 32'h0,   MEM_WORD, 32'h10, 32'hDEADBEEF,
                32'h0,        0, 0, 32'h0};
    tbl[1]  = '{1, 32'h10,  MEM_NONE, 32'h0,  32'h0,
                32'hDEADBEEF, 1, 0, 32'h0};
    tbl[2]  = '{0, 32'h0,   MEM_NONE, 32'h0,  32'h0,
                32'hDEADBEEF, 0, 0, 32'h0};
    tbl[3]  = '{0, 32'h0,   MEM_BYTE, 32'h13, 32'hAA,
                32'hDEADBEEF, 0, 0, 32'h0};
    tbl[4]  = '{1, 32'h10,  MEM_NONE, 32'h0,  32'h0,
                32'hAAADBEEF, 1, 0, 32'h0};
    tbl[5]  = '{1, 32'h12,  MEM_HALF, 32'h10, 32'h1234,
                32'hAAAD1234, 1, 0, 32'h0};
    tbl[6]  = '{0, 32'h0,   MEM_HALF, 32'h11, 32'hFFFF,
                32'hAAAD1234, 0, 1, 32'h11};
    tbl[7]  = '{0, 32'h0,   MEM_WORD, 32'h12, 32'h0,
                32'hAAAD1234, 0, 1, 32'h12};
    tbl[8]  = '{1, 32'h10,  MEM_NONE, 32'h0,  32'h0,
                32'hAAAD1234, 1, 0, 32'h12};
    tbl[9]  = '{1, 32'h20,  MEM_WORD, 32'h20, 32'h55AA55AA,
                32'h55AA55AA, 1, 0, 32'h12};
    tbl[10] = '{1, 32'(DEPTH*4), MEM_NONE, 32'h0, 32'h0,
                32'h0,        1, 1, 32'(DEPTH*4)};
    tbl[11] = '{1, 32'h10,  MEM_NONE, 32'h0,  32'h0,
                32'hAAAD1234, 1, 0, 32'(DEPTH*4)};
    tbl[12] = '{1, 32'h800, MEM_HALF, 32'h21, 32'hBEEF,
                32'h0,        1, 1, 32'h21};
    tbl[13] = '{1, 32'h20,  MEM_NONE, 32'hFFFFFFF1, 32'h0,
                32'h55AA55AA, 1, 0, 32'h21};

    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].re, tbl[i].raddr, tbl[i].mode,
           tbl[i].waddr, tbl[i].wdata);
      chk($sformatf("vec%0d.data", i),  ram_read_data, tbl[i].e_data);
      chk($sformatf("vec%0d.valid", i), 32'(ram_read_valid),
          32'(tbl[i].e_valid));
      chk($sformatf("vec%0d.fault", i), 32'(ram_fault),
          32'(tbl[i].e_fault));
      chk($sformatf("vec%0d.faddr", i), ram_fault_addr, tbl[i].e_faddr);
    end

    // Read accepted, then reset asserted mid-cycle with traffic on inputs.
    step(1, 32'h10, MEM_NONE, 32'h0, 32'h0);
    chk("prerst.data", ram_read_data, 32'hAAAD1234);
    chk("prerst.valid", 32'(ram_read_valid), 32'h1);
    #2;
    rst_n          = 1'b0;
    ram_read_en    = 1'b1;
    ram_write_mode = MEM_WORD;
    ram_write_addr = 32'h10;
    ram_write_data = 32'h0;
    #1;
    chk_zero("inrst");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("inrst2");
    @(negedge clk);
    ram_read_en    = 1'b0;
    ram_write_mode = MEM_NONE;
    rst_n          = 1'b1;
    m_data  = '0;
    m_valid = 1'b0;
    m_fault = 1'b0;
    m_faddr = '0;
    step(0, 32'h0, MEM_NONE, 32'h0, 32'h0);
    chk_model("postrst");
    step(1, 32'h10, MEM_NONE, 32'h0, 32'h0);
    chk("retain.data", ram_read_data, 32'hAAAD1234);
    chk("retain.valid", 32'(ram_read_valid), 32'h1);

    for (int i = 0; i < DEPTH; i++) begin
      step(0, 32'h0, MEM_WORD, 32'(i*4), $urandom);
      chk_model("init");
    end

    for (int n = 0; n < 3000; n++) begin
      re = 1'($urandom);
      ra = rnd_addr();
      wa = ($urandom_range(0, 3) == 0) ? ra : rnd_addr();
      md = 2'($urandom);
      step(re, ra, md, wa, $urandom);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, meaning number of 32-bit words stored; power of two.
REQ-002 SHALL have parameter ADDR_BASE, default 32'h0000_0000, meaning byte address of word 0.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset: asynchronous assert, active-low.
REQ-005 SHALL have port ram_read_en, input, 1, meaning read request this cycle.
REQ-006 SHALL have port ram_read_addr, input, XLEN, meaning byte address of the read.
REQ-007 SHALL have port ram_read_data, output, XLEN, meaning registered aligned word returned for the read.
REQ-008 SHALL have port ram_read_valid, output, 1, meaning ram_read_data holds the response to last cycle's read.
REQ-009 SHALL have port ram_write_mode, input, 2, meaning 00 none, 01 byte, 10 halfword, 11 word.
REQ-010 SHALL have port ram_write_addr, input, XLEN, meaning byte address of the write.
REQ-011 SHALL have port ram_write_data, input, XLEN, meaning store data, right-justified (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port ram_fault, output, 1, meaning one-cycle pulse for a rejected access.
REQ-013 SHALL have port ram_fault_addr, output, XLEN, meaning byte address of the most recent rejected access.

Function
REQ-014 SHALL store little-endian; word index = (addr - ADDR_BASE) >> 2; lane = addr[1:0].
REQ-015 SHALL perform a write at the clock edge of the request cycle, updating only the addressed lanes: byte -> lane addr[1:0]; half -> lanes addr[1]*2 and +1; word -> all four.
REQ-016 SHALL reject, with no storage change, a half write with addr[0]=1, a word write with addr[1:0]!=0, and any write whose word index is >= DEPTH or whose address is below ADDR_BASE.
REQ-017 SHALL return the whole word containing ram_read_addr, ignoring addr[1:0], one cycle after ram_read_en (latency 1).
REQ-018 SHALL assert ram_read_valid for exactly one cycle per accepted read; back-to-back reads yield back-to-back valid cycles.
REQ-019 SHALL, for an out-of-range read, return 32'h0 with ram_read_valid=1 and raise ram_fault.
REQ-020 SHALL, for a read and a write to the same word in the same cycle, return the post-write merged word (write-first).
REQ-021 SHALL hold ram_read_data at its last value when ram_read_en=0; ram_read_valid=0 in that case.
REQ-022 SHALL register ram_fault one cycle after the offending request; if read and write both fault in one cycle, ram_fault_addr SHALL take the write address.
REQ-023 SHALL treat ram_write_mode=00 as no access regardless of address; no fault.

Reset
REQ-024 SHALL drive ram_read_data=0, ram_read_valid=0, ram_fault=0, ram_fault_addr=0 while rst_n=0.
REQ-025 SHALL NOT clear storage contents on reset; contents are undefined after power-up.
REQ-026 SHALL ignore reads and writes presented while rst_n=0; a read accepted the cycle before reset assertion SHALL produce no valid after reset release.

Structure
REQ-027 SHALL take XLEN_WIDTH and true/false from the shared const definitions and write-mode encodings (MEM_NONE/BYTE/HALF/WORD) from the shared inst definitions, also used by the memory stage.
REQ-028 SHALL isolate lane-enable and data-replication logic in one sub-module, ram_lane_gen (mode, addr[1:0], data -> 4-bit byte enable, 32-bit lane-aligned data, misaligned flag).
REQ-029 SHALL implement storage as a word array with per-byte-enable writes, inferable as block RAM.

Verification
REQ-030 SHALL cover: word write 32'hDEADBEEF at 0x10, read 0x10 next cycle -> ram_read_data=32'hDEADBEEF, valid one cycle after the read.
REQ-031 SHALL cover: byte write 8'hAA at 0x13 over DEADBEEF, read 0x10 -> 32'hAAADBEEF; half write 16'h1234 at 0x10 -> 32'hAAAD1234.
REQ-032 SHALL cover: half write at 0x11 and word write at 0x12 -> ram_fault pulse, ram_fault_addr=0x11 then 0x12, word at 0x10 unchanged.
REQ-033 SHALL cover: same-cycle word write 32'h55AA55AA and read at 0x20 -> read returns 32'h55AA55AA next cycle.
REQ-034 SHALL cover: read at byte address DEPTH*4 -> ram_read_data=0, ram_read_valid=1, ram_fault=1.
REQ-035 SHALL cover: read at 0x10 then rst_n low mid-cycle -> outputs zero immediately, no valid after release, word at 0x10 retained.
